in_signal_rx: RTL and testbench
===============================

Name: in_signal_rx

Overview:
Receive end of the 3-bit symbol interface driven by OutModule-style sources (OutSignal[2:0] plus a qualifying OutSignal0 bit). The block samples the symbol whenever the strobe is high and buffers it in a small FIFO. It then hands symbols to downstream logic over a ready/valid pop port. It sits beside InModule instances in the Sub004-level hierarchy and adds buffering, overflow tracking and a flush control.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
SYM_W, 3, symbol width; must match the OutSignal/InSignal bus width.

Ports:
clk  input  1  single block clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
InSignal  input  SYM_W  incoming symbol.
InSignal0  input  1  strobe; symbol on InSignal is valid this cycle.
flush  input  1  synchronous FIFO clear.
clr_ovf  input  1  synchronous clear of the overflow flag.
rd_ready  input  1  consumer accepts rd_data this cycle.
rd_valid  output  1  FIFO non-empty.
rd_data  output  SYM_W  head-of-FIFO symbol.
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky; set when a strobed symbol was dropped.

Behaviour:
- Reset (rst_n=0, asynchronous): rd_valid=0, rd_data=0, count=0, overflow=0. Read and write pointers return to 0. All buffered symbols are discarded, including during a burst. Release takes effect at the next rising edge.
- push = InSignal0. pop = rd_valid & rd_ready. Both are evaluated at each rising clk edge.
- Write latency: a symbol pushed at edge N into an empty FIFO gives rd_valid=1 and rd_data=that symbol after edge N, i.e. visible in cycle N+1. There is no combinational path from InSignal to rd_data.
- rd_data always shows mem[rd_ptr] when rd_valid=1. It is forced to 0 when empty.
- Pop: the head advances at the edge where pop=1. The next entry, or 0 if the FIFO is now empty, appears the following cycle.
- Pointers have width $clog2(DEPTH) and wrap from DEPTH-1 to 0. Occupancy is tracked by count, not by pointer compare.
- Push and pop in the same cycle:
  - Allowed at any occupancy, including full.
  - When full, the pop frees the slot in the same edge and the push is accepted.
  - count is unchanged.
- Push when full without pop: the symbol is dropped, pointers and count are unchanged, and overflow is set at that edge.
- Push and pop in the same cycle when empty: only the push takes effect, because pop is impossible while rd_valid=0.
- flush=1:
  - At the edge, pointers and count go to 0 and rd_valid goes to 0 next cycle.
  - A simultaneous push is discarded and does not set overflow.
  - A simultaneous pop is ignored.
  - overflow is not affected.
- clr_ovf=1 clears overflow. If a new drop occurs at the same edge, set wins and overflow stays 1.
- Occupancy FSM (encoded by count): EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH).
  - EMPTY->PARTIAL on push.
  - PARTIAL->FULL on push with no pop at count=DEPTH-1.
  - FULL->PARTIAL on pop with no push.
  - PARTIAL->EMPTY on pop with no push at count=1.
  - Any state->EMPTY on flush or reset.
- X on InSignal while InSignal0=0 is ignored. It must not propagate to any output.

Optional Feature:
IN_SIGNAL_RX_OVF_CNT_EN
- Defined:
  - Adds output ovf_cnt[7:0], which counts dropped symbols.
  - Reset to 0; increments on each drop; saturates at 255.
  - Cleared by clr_ovf, with the same-edge rule: a new drop together with clr_ovf loads 1.
  - flush does not affect it.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package in_signal_pkg:
  - localparam SYM_W=3 and typedef sym_t (logic [SYM_W-1:0]).
  - Enum occ_state_t {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} for debug and assertions.
  - Shared with future OutSignal-side transmitter blocks.
- One sub-module in_signal_fifo:
  - Storage, pointers, count, push/pop/flush.
  - Reports a full signal and a push-accepted signal.
- Top in_signal_rx contains the drop detection, overflow flag and the optional counter.

Test Plan:
- Reset then push 3'b101, 3'b010 on consecutive edges with rd_ready=0 -> count=2, rd_valid=1, rd_data=3'b101. Then rd_ready=1 for 2 cycles -> rd_data 3'b010 then rd_valid=0, count=0, rd_data=0.
- DEPTH=4: push 5 symbols 1..5 with no pop -> count=4, overflow=1, pops return 1,2,3,4 in order. With the macro defined, ovf_cnt=1.
- Full FIFO, push 3'b111 and pop in the same cycle -> count stays 4, overflow stays 0. The last pop returns 3'b111 after the remaining 3 entries.
- Wrap-around: 10 single push/pop pairs, values 0..7 repeating -> every symbol is returned in order and count never exceeds 1.
- flush asserted together with push 3'b011 at count=2 -> count=0 and rd_valid=0 next cycle, overflow unchanged. A subsequent pop attempt has no effect.
- Drop and clr_ovf on the same edge -> overflow=1. rst_n pulsed low mid-burst with count=3 -> all outputs are 0 immediately, asynchronously.

Source files
------------

// File: rtl/in_signal_pkg.sv
// rtl/in_signal_pkg.sv - shared symbol types and FIFO occupancy states for InSignal/OutSignal blocks
package in_signal_pkg;
    localparam int SYM_W = 3;

    typedef logic [SYM_W-1:0] sym_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_state_t;
endpackage

// File: rtl/in_signal_fifo.sv
// rtl/in_signal_fifo.sv - symbol FIFO with count-tracked occupancy, simultaneous push/pop and flush
module in_signal_fifo #(
    parameter int DEPTH = 4,
    parameter int SYM_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SYM_W-1:0]         wrData,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    output logic [SYM_W-1:0]         rdData,
    output logic                     rdValid,
    output logic                     full,
    output logic                     pushAcc,
    output logic [$clog2(DEPTH):0]   count
);
    import in_signal_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [SYM_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [PW:0]      cnt;
    logic [PW:0]      cntNext;
    logic             popAcc;
    occ_state_t       occState;
    occ_state_t       occNext;

    // A pop on a full FIFO frees the slot the same edge, so the push is taken too.
    always_comb begin
        popAcc  = pop & (occState != OCC_EMPTY) & ~flush;
        pushAcc = push & ~flush & ((occState != OCC_FULL) | popAcc);
        cntNext = cnt;
        occNext = occState;
        if (flush) begin
            cntNext = '0;
        end else if (pushAcc & ~popAcc) begin
            cntNext = cnt + 1'b1;
        end else if (popAcc & ~pushAcc) begin
            cntNext = cnt - 1'b1;
        end
        if (cntNext == '0) begin
            occNext = OCC_EMPTY;
        end else if (cntNext == FULL_CNT) begin
            occNext = OCC_FULL;
        end else begin
            occNext = OCC_PARTIAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occState <= OCC_EMPTY;
            cnt      <= '0;
            wrPtr    <= '0;
            rdPtr    <= '0;
        end else begin
            occState <= occNext;
            cnt      <= cntNext;
            if (flush) begin
                wrPtr <= '0;
                rdPtr <= '0;
            end else begin
                if (pushAcc) wrPtr <= wrPtr + 1'b1;
                if (popAcc)  rdPtr <= rdPtr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the read port is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (pushAcc) mem[wrPtr] <= wrData;
    end

    assign rdValid = (occState != OCC_EMPTY);
    assign full    = (occState == OCC_FULL);
    assign rdData  = rdValid ? mem[rdPtr] : '0;
    assign count   = cnt;
endmodule

// File: rtl/in_signal_rx.sv
// rtl/in_signal_rx.sv - InSignal receiver: strobed capture into FIFO, sticky overflow, optional drop counter (IN_SIGNAL_RX_OVF_CNT_EN)
module in_signal_rx #(
    parameter int DEPTH = 4,
    parameter int SYM_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SYM_W-1:0]         InSignal,
    input  logic                     InSignal0,
    input  logic                     flush,
    input  logic                     clr_ovf,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [SYM_W-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef IN_SIGNAL_RX_OVF_CNT_EN
    ,
    output logic [7:0]               ovf_cnt
`endif
);
    import in_signal_pkg::*;

    logic pop;
    logic full;
    logic pushAcc;
    logic drop;

    assign pop = rd_valid & rd_ready;

    in_signal_fifo #(
        .DEPTH (DEPTH),
        .SYM_W (SYM_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrData  (InSignal),
        .push    (InSignal0),
        .pop     (pop),
        .flush   (flush),
        .rdData  (rd_data),
        .rdValid (rd_valid),
        .full    (full),
        .pushAcc (pushAcc),
        .count   (count)
    );

    // A symbol discarded by flush is not a drop.
    assign drop = InSignal0 & full & ~pushAcc & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef IN_SIGNAL_RX_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (drop) begin
            if (clr_ovf) begin
                ovf_cnt <= 8'd1;
            end else if (ovf_cnt != 8'hFF) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
        end else if (clr_ovf) begin
            ovf_cnt <= '0;
        end
    end
`endif
endmodule

// File: tb/tb_in_signal_rx.sv
// tb/tb_in_signal_rx.sv - scoreboard bench for in_signal_rx with directed cases and randomized traffic
module tb_in_signal_rx;
    localparam int DEPTH = 4;
    localparam int SYM_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [SYM_W-1:0] InSignal;
    logic             InSignal0;
    logic             flush;
    logic             clr_ovf;
    logic             rd_ready;
    logic             rd_valid;
    logic [SYM_W-1:0] rd_data;
    logic [$clog2(DEPTH):0] count;
    logic             overflow;
`ifdef IN_SIGNAL_RX_OVF_CNT_EN
    logic [7:0]       ovf_cnt;
`endif

    in_signal_rx #(.DEPTH(DEPTH), .SYM_W(SYM_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .InSignal  (InSignal),
        .InSignal0 (InSignal0),
        .flush     (flush),
        .clr_ovf   (clr_ovf),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .count     (count),
        .overflow  (overflow)
`ifdef IN_SIGNAL_RX_OVF_CNT_EN
        ,
        .ovf_cnt   (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;
    bit monOn   = 1'b0;

    logic [SYM_W-1:0] expQ [$];
    bit mOvf    = 1'b0;
    int mOvfCnt = 0;

    task automatic check(string name, int act, int exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: before each edge compare visible state and retire the head on a handshake.
    always @(negedge clk) begin
        if (monOn && rst_n) begin
            check("count", int'(count), expQ.size());
            check("rd_valid", int'(rd_valid), int'(expQ.size() != 0));
            check("overflow", int'(overflow), int'(mOvf));
`ifdef IN_SIGNAL_RX_OVF_CNT_EN
            check("ovf_cnt", int'(ovf_cnt), mOvfCnt);
`endif
            if (expQ.size() == 0) begin
                check("rd_data_empty", int'(rd_data), 0);
            end else if (rd_ready && !flush) begin
                check("rd_data_pop", int'(rd_data), int'(expQ.pop_front()));
            end else begin
                check("rd_data_head", int'(rd_data), int'(expQ[0]));
            end
        end
    end

    // Drive one cycle of inputs, then apply the queue-level effect of that edge to the model.
    task automatic step(bit p, logic [SYM_W-1:0] s, bit rdy, bit fl, bit clr);
        bit dropped;
        dropped   = 1'b0;
        InSignal0 = p;
        InSignal  = p ? s : 'x;
        rd_ready  = rdy;
        flush     = fl;
        clr_ovf   = clr;
        @(posedge clk);
        #1;
        if (fl) begin
            expQ.delete();
        end else if (p) begin
            if (expQ.size() < DEPTH) expQ.push_back(s);
            else dropped = 1'b1;
        end
        if (dropped) begin
            mOvf    = 1'b1;
            mOvfCnt = clr ? 1 : ((mOvfCnt >= 255) ? 255 : mOvfCnt + 1);
        end else if (clr) begin
            mOvf    = 1'b0;
            mOvfCnt = 0;
        end
    endtask

    task automatic checkAllZero(string tag);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_rd_valid"}, int'(rd_valid), 0);
        check({tag, "_rd_data"}, int'(rd_data), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
`ifdef IN_SIGNAL_RX_OVF_CNT_EN
        check({tag, "_ovf_cnt"}, int'(ovf_cnt), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; InSignal = '0; InSignal0 = 1'b0;
        flush = 1'b0; clr_ovf = 1'b0; rd_ready = 1'b0;
        #12;
        checkAllZero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        monOn = 1'b1;

        // Two pushes held, then drained.
        step(1, 3'b101, 0, 0, 0);
        step(1, 3'b010, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // Five pushes into four slots, then drain in order.
        for (int i = 1; i <= 5; i++) step(1, 3'(i), 0, 0, 0);
        check("overflow_after_fill", int'(overflow), 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);

        // Full FIFO with simultaneous push and pop.
        for (int i = 1; i <= 4; i++) step(1, 3'(i), 0, 0, 0);
        step(1, 3'b111, 1, 0, 0);
        check("full_pushpop_ovf", int'(overflow), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);

        // Wrap-around through the pointers.
        for (int i = 0; i < 10; i++) begin
            step(1, 3'(i % 8), 0, 0, 0);
            step(0, 0, 1, 0, 0);
        end

        // Flush with a simultaneous push and a pending pop.
        step(1, 3'b001, 0, 0, 0);
        step(1, 3'b110, 0, 0, 0);
        step(1, 3'b011, 1, 1, 0);
        step(0, 0, 1, 0, 0);

        // Drop together with clr_ovf: set wins.
        for (int i = 0; i < 4; i++) step(1, 3'(i + 2), 0, 0, 0);
        step(1, 3'b000, 0, 0, 0);
        step(1, 3'b100, 0, 0, 1);
        check("drop_clr_same_edge", int'(overflow), 1);
        step(0, 0, 1, 0, 0);

        // Asynchronous reset with three symbols buffered.
        InSignal0 = 1'b0; rd_ready = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
        check("pre_reset_count", int'(count), 3);
        #2;
        monOn = 1'b0;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        expQ.delete(); mOvf = 1'b0; mOvfCnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        monOn = 1'b1;

        // Randomized traffic with shifting consumer pressure.
        for (int i = 0; i < 600; i++) begin
            int rdyPct;
            rdyPct = ((i / 60) % 3 == 0) ? 15 : (((i / 60) % 3 == 1) ? 50 : 85);
            step($urandom_range(0, 99) < 60,
                 3'($urandom),
                 $urandom_range(0, 99) < rdyPct,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 19) == 0);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        monOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end
endmodule
